// File: rtl/counter_pkg.sv
// Shared types and parameter checks for the stream-side index counters.
// Legality of the down_counter geometry is decided here so every user agrees on it.
package counter_pkg;

    typedef enum logic [1:0] {
        eIDLE,
        eCOUNTING,
        eDONE
    } down_state_t;

    // INPUT_MAX must be at least 1 and every index must fit in WORD_SIZE bits.
    function automatic bit down_params_ok(input int input_max, input int word_size);
        bit fits;
        if (word_size >= 31)
            fits = 1'b1;
        else
            fits = ((64'd1 << word_size) >= 64'(input_max));
        return (input_max >= 1) && (word_size >= 1) && fits;
    endfunction

endpackage

// File: rtl/down_counter.sv
// Reverse index generator: emits INPUT_MAX-1 down to 0 over a valid/ready stream,
// then pulses done_o for one cycle. Abort drops the run silently.
module down_counter #(
    parameter int WORD_SIZE = 16,
    parameter int INPUT_MAX = 10
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 ready_i,
    output logic                 valid_o,
    output logic [WORD_SIZE-1:0] data_o,
    output logic                 last_o,
    output logic                 busy_o,
    output logic                 done_o
);
    import counter_pkg::*;

    if (!down_params_ok(INPUT_MAX, WORD_SIZE)) begin : g_bad_params
        $error("down_counter: illegal INPUT_MAX=%0d / WORD_SIZE=%0d", INPUT_MAX, WORD_SIZE);
    end

    localparam logic [WORD_SIZE-1:0] LOAD_VAL = WORD_SIZE'(INPUT_MAX - 1);

    down_state_t          state_q, state_d;
    logic [WORD_SIZE-1:0] data_q, data_d;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        case (state_q)
            eIDLE: begin
                if (start_i) begin
                    state_d = eCOUNTING;
                    data_d  = LOAD_VAL;
                end
            end
            eCOUNTING: begin
                // Abort wins over a handshake landing in the same cycle.
                if (abort_i) begin
                    state_d = eIDLE;
                    data_d  = '0;
                end else if (ready_i) begin
                    if (data_q == '0) begin
                        state_d = eDONE;
                        data_d  = '0;
                    end else begin
                        data_d  = data_q - 1'b1;
                    end
                end
            end
            eDONE: begin
                if (start_i) begin
                    state_d = eCOUNTING;
                    data_d  = LOAD_VAL;
                end else begin
                    state_d = eIDLE;
                    data_d  = '0;
                end
            end
            default: begin
                state_d = eIDLE;
                data_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= eIDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    // Every output decodes registers only, so nothing combinational reaches the port from inputs.
    assign valid_o = (state_q == eCOUNTING);
    assign busy_o  = (state_q == eCOUNTING);
    assign done_o  = (state_q == eDONE);
    assign data_o  = data_q;
    assign last_o  = valid_o && (data_q == '0);

endmodule

// File: tb/tb_down_counter.sv
// Scoreboard bench for down_counter: stimulus queues expected beats and done pulses,
// a negedge monitor pops and compares them as the DUT presents handshakes.
module tb_down_counter;

    typedef struct packed {
        logic [15:0] d;
        logic        l;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        a_start = 1'b0, a_abort = 1'b0, a_ready = 1'b1;
    logic        a_valid, a_last, a_busy, a_done;
    logic [15:0] a_data;

    logic        b_start = 1'b0, b_abort = 1'b0, b_ready = 1'b1;
    logic        b_valid, b_last, b_busy, b_done;
    logic [0:0]  b_data;

    beat_t       exp_q[$];
    int          done_q[$];
    int          n_checks = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    down_counter #(.WORD_SIZE(16), .INPUT_MAX(10)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(a_start), .abort_i(a_abort),
        .ready_i(a_ready), .valid_o(a_valid), .data_o(a_data), .last_o(a_last),
        .busy_o(a_busy), .done_o(a_done)
    );

    down_counter #(.WORD_SIZE(1), .INPUT_MAX(1)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .start_i(b_start), .abort_i(b_abort),
        .ready_i(b_ready), .valid_o(b_valid), .data_o(b_data), .last_o(b_last),
        .busy_o(b_busy), .done_o(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beats(input int from, input int to);
        for (int v = from; v >= to; v--) exp_q.push_back(beat_t'{16'(v), (v == 0)});
    endtask

    task automatic pulse_start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
    endtask

    task automatic wait_val(input logic [15:0] v);
        for (int i = 0; i < 40; i++) begin
            if (a_valid && a_data == v) return;
            step();
        end
        chk("wait_data_timeout", 32'(a_data), 32'(v));
    endtask

    task automatic wait_done();
        for (int i = 0; i < 40; i++) begin
            if (a_done) return;
            step();
        end
        chk("wait_done_timeout", 32'(a_done), 32'd1);
    endtask

    // Monitor: one pop per accepted beat, one pop per done cycle.
    always @(negedge clk) begin
        if (rst_n && a_valid && a_ready && !a_abort) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'(a_data), 32'hFFFF_FFFF);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", 32'(a_data), 32'(e.d));
                chk("beat_last", 32'(a_last), 32'(e.l));
            end
        end
        if (rst_n && a_done) begin
            if (done_q.size() == 0) chk("unexpected_done", 32'(a_done), 32'd0);
            else begin
                void'(done_q.pop_front());
                chk("done_valid_low", 32'(a_valid), 32'd0);
            end
        end
    end

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", 32'(a_valid), 0);
        chk("rst_data",  32'(a_data),  0);
        chk("rst_last",  32'(a_last),  0);
        chk("rst_busy",  32'(a_busy),  0);
        chk("rst_done",  32'(a_done),  0);
        chk("rst_b_valid", 32'(b_valid), 0);
        #3 rst_n = 1'b1;
        step();
        chk("post_rst_valid", 32'(a_valid), 0);
        chk("post_rst_data",  32'(a_data),  0);
        chk("post_rst_done",  32'(a_done),  0);

        // Basic run with ready held
        push_beats(9, 0);
        done_q.push_back(1);
        pulse_start_a();
        chk("first_data", 32'(a_data), 9);
        chk("first_busy", 32'(a_busy), 1);
        repeat (12) step();
        chk("idle_valid", 32'(a_valid), 0);
        chk("idle_busy",  32'(a_busy),  0);
        chk("idle_done",  32'(a_done),  0);

        // Backpressure at 5, plus start ignored mid-run
        push_beats(9, 0);
        done_q.push_back(1);
        pulse_start_a();
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        wait_val(16'd5);
        a_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_data",  32'(a_data),  5);
            chk("stall_valid", 32'(a_valid), 1);
        end
        a_ready = 1'b1;
        wait_done();

        // Back-to-back: start in the done cycle
        push_beats(9, 0);
        done_q.push_back(1);
        a_start = 1'b1;
        step();
        a_start = 1'b0;
        chk("b2b_valid", 32'(a_valid), 1);
        chk("b2b_data",  32'(a_data),  9);
        step();
        wait_done();

        // Abort at 3 with ready high
        step();
        push_beats(9, 4);
        pulse_start_a();
        wait_val(16'd3);
        a_abort = 1'b1;
        step();
        a_abort = 1'b0;
        chk("abort_valid", 32'(a_valid), 0);
        chk("abort_data",  32'(a_data),  0);
        chk("abort_busy",  32'(a_busy),  0);
        chk("abort_done",  32'(a_done),  0);
        repeat (3) step();
        chk("abort_no_done", 32'(a_done), 0);

        // Asynchronous reset between edges
        push_beats(9, 7);
        pulse_start_a();
        wait_val(16'd6);
        a_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(a_valid), 0);
        chk("async_data",  32'(a_data),  0);
        chk("async_busy",  32'(a_busy),  0);
        chk("async_last",  32'(a_last),  0);
        step();
        #3 rst_n = 1'b1;
        a_ready = 1'b1;
        step();
        push_beats(9, 0);
        done_q.push_back(1);
        pulse_start_a();
        chk("fresh_data", 32'(a_data), 9);
        wait_done();
        step();

        // INPUT_MAX=1 single beat
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        chk("one_valid", 32'(b_valid), 1);
        chk("one_data",  32'(b_data),  0);
        chk("one_last",  32'(b_last),  1);
        step();
        chk("one_done",  32'(b_done),  1);
        chk("one_valid_off", 32'(b_valid), 0);
        step();
        chk("one_idle_done", 32'(b_done), 0);

        // Drain the scoreboard
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0 && done_q.size() == 0) break;
            step();
        end
        chk("drain_beats", 32'(exp_q.size()), 0);
        chk("drain_done",  32'(done_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
